sha_block_sequencer: RTL and testbench



---
 rtl/sha_ctrl_pkg.sv | 30 +++
 rtl/sha_round_counter.sv | 24 ++
 rtl/sha_block_sequencer.sv | 100 ++++++++++
 tb/tb_sha_block_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sha_ctrl_pkg.sv
// sha_ctrl_pkg: shared state, block-select and chunk-index encodings for the SHA-256 mining core.
package sha_ctrl_pkg;

    localparam int ROUNDS = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_CHUNK,
        S_LOAD,
        S_ROUND,
        S_ACCUM,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [1:0] BSEL_IV = 2'd0;
    localparam logic [1:0] BSEL_C1 = 2'd1;
    localparam logic [1:0] BSEL_C2 = 2'd2;

    localparam logic [1:0] CIDX_H0 = 2'd0;
    localparam logic [1:0] CIDX_H1 = 2'd1;
    localparam logic [1:0] CIDX_H2 = 2'd2;

    // Select level presented while accumulating the chunk just compressed.
    function automatic logic [1:0] bsel_after(input logic [1:0] cidx);
        return (cidx == CIDX_H1) ? BSEL_C2 : BSEL_C1;
    endfunction

endpackage

// File: rtl/sha_round_counter.sv
// sha_round_counter: compression round index with enable, terminal-count flag and wrap to 0.
module sha_round_counter #(
    parameter int ROUNDS = sha_ctrl_pkg::ROUNDS,
    localparam int W = $clog2(ROUNDS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = cnt_q == W'(ROUNDS - 1);
    assign cnt_o = cnt_q;

    always_comb cnt_d = en_i ? (tc_o ? '0 : cnt_q + 1'b1) : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/sha_block_sequencer.sv
// sha_block_sequencer: control FSM for the two-chunk header hash of the SHA-256 mining core.
// Defining DOUBLE_HASH_EN adds the digest capture and the one-chunk second hash.
module sha_block_sequencer
    import sha_ctrl_pkg::*;
#(
    parameter int ROUNDS = sha_ctrl_pkg::ROUNDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      chunk_valid,
    output logic                      chunk_req,
    output logic [1:0]                chunk_idx,
    output logic [1:0]                block_sel,
    output logic                      wv_load,
    output logic                      round_en,
    output logic [$clog2(ROUNDS)-1:0] round_idx,
    output logic                      digest_capture,
    output logic                      busy,
    output logic                      done
);

    state_t     state_q, state_d;
    logic [1:0] bsel_q, bsel_d;
    logic [1:0] cidx_q, cidx_d;
    logic       last_round;

    sha_round_counter #(.ROUNDS(ROUNDS)) u_round_counter (
        .clk  (clk),
        .rst  (rst),
        .en_i (round_en),
        .cnt_o(round_idx),
        .tc_o (last_round)
    );

    always_comb begin
        state_d = state_q;
        bsel_d  = bsel_q;
        cidx_d  = cidx_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_INIT;
                bsel_d  = BSEL_IV;
                cidx_d  = CIDX_H0;
            end
            S_INIT:       state_d = S_WAIT_CHUNK;
            S_WAIT_CHUNK: state_d = chunk_valid ? S_LOAD : S_WAIT_CHUNK;
            S_LOAD:       state_d = S_ROUND;
            // block_sel moves on entry to ACCUM so H sees each new level for exactly one edge there
            S_ROUND: if (last_round) begin
                state_d = S_ACCUM;
                bsel_d  = bsel_after(cidx_q);
            end
            S_ACCUM: begin
                if (cidx_q == CIDX_H0) begin
                    state_d = S_WAIT_CHUNK;
                    cidx_d  = CIDX_H1;
                end
`ifdef DOUBLE_HASH_EN
                else if (cidx_q == CIDX_H1) state_d = S_CAPTURE;
`endif
                else state_d = S_DONE;
            end
`ifdef DOUBLE_HASH_EN
            S_CAPTURE: begin
                state_d = S_INIT;
                bsel_d  = BSEL_IV;
                cidx_d  = CIDX_H2;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            bsel_q  <= BSEL_IV;
            cidx_q  <= CIDX_H0;
        end else begin
            state_q <= state_d;
            bsel_q  <= bsel_d;
            cidx_q  <= cidx_d;
        end

    assign chunk_req = state_q == S_WAIT_CHUNK;
    assign chunk_idx = cidx_q;
    assign block_sel = bsel_q;
    assign wv_load   = state_q == S_LOAD;
    assign round_en  = state_q == S_ROUND;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
`ifdef DOUBLE_HASH_EN
    assign digest_capture = state_q == S_CAPTURE;
`else
    assign digest_capture = 1'b0;
`endif

endmodule

// File: tb/tb_sha_block_sequencer.sv
// tb_sha_block_sequencer: expected per-cycle outputs are built as a timeline of job phases,
// then compared against the DUT every cycle; job-level timing is also pinned with literals.
module tb_sha_block_sequencer;

`ifdef DOUBLE_HASH_EN
    localparam int NCH = 3, T_DONE = 205;
`else
    localparam int NCH = 2, T_DONE = 136;
`endif

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, chunk_valid = 1'b0;
    logic       chunk_req, wv_load, round_en, digest_capture, busy, done;
    logic [1:0] chunk_idx, block_sel;
    logic [5:0] round_idx;

    always #5 clk = ~clk;

    sha_block_sequencer #(.ROUNDS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .chunk_valid(chunk_valid),
        .chunk_req(chunk_req), .chunk_idx(chunk_idx), .block_sel(block_sel),
        .wv_load(wv_load), .round_en(round_en), .round_idx(round_idx),
        .digest_capture(digest_capture), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic       st, cv, req;
        logic [1:0] idx, bsel;
        logic       wv, ren;
        logic [5:0] ridx;
        logic       cap, bsy, dn;
    } rec_t;

    rec_t       q[$];
    logic [1:0] m_bsel = 2'd0, m_idx = 2'd0, prev_bsel = 2'd0;
    int         checks = 0, errors = 0;
    int         jc = 0, done_cyc, n_done, wv_a, wv_b, cap_cyc, idx2_cyc;
    int         ch_cyc[$], ch_val[$];

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic push(input logic st, cv, req, wv, ren, input int ridx, input logic cap, bsy, dn);
        rec_t r;
        r.st = st; r.cv = cv; r.req = req; r.idx = m_idx; r.bsel = m_bsel;
        r.wv = wv; r.ren = ren; r.ridx = 6'(ridx); r.cap = cap; r.bsy = bsy; r.dn = dn;
        q.push_back(r);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) push(1'b0, i[0], 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One job: idle cycle carrying start, INIT, then per chunk WAIT(+stall)/LOAD/64 rounds/ACCUM, DONE.
    task automatic job(input int stall, input logic poke);
        push(1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        m_bsel = 2'd0; m_idx = 2'd0;
        push(1'b0, 1'b1, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < NCH; c++) begin
            if (c == 2) begin
                push(1'b0, 1'b1, 0, 0, 0, 0, 1, 1, 0);
                m_bsel = 2'd0; m_idx = 2'd2;
                push(1'b0, 1'b1, 0, 0, 0, 0, 0, 1, 0);
            end
            m_idx = 2'(c);
            for (int s = 0; s < stall; s++) push(1'b0, 1'b0, 1, 0, 0, 0, 0, 1, 0);
            push(1'b0, 1'b1, 1, 0, 0, 0, 0, 1, 0);
            push(1'b0, 1'b1, 0, 1, 0, 0, 0, 1, 0);
            for (int r = 0; r < 64; r++) push(poke && c == 0 && r == 10, 1'b1, 0, 0, 1, r, 0, 1, 0);
            m_bsel = (c == 1) ? 2'd2 : 2'd1;
            push(1'b0, 1'b1, 0, 0, 0, 0, 0, 1, 0);
        end
        push(poke, 1'b1, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic play(input int n);
        rec_t        e;
        logic [15:0] act, ex;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            @(negedge clk);
            e   = q.pop_front();
            act = {chunk_req, chunk_idx, block_sel, wv_load, round_en, round_idx, digest_capture, busy, done};
            ex  = {e.req, e.idx, e.bsel, e.wv, e.ren, e.ridx, e.cap, e.bsy, e.dn};
            if (e.st && !e.bsy) begin
                jc = 0; n_done = 0; done_cyc = -1; wv_a = -1; wv_b = -1; cap_cyc = -1; idx2_cyc = -1;
                ch_cyc.delete(); ch_val.delete();
            end else jc++;
            checks++;
            if (act !== ex) begin
                errors++;
                if (errors < 20) $display("FAIL cycle %0d: outputs got %h want %h", jc, act, ex);
            end
            if (done) begin n_done++; done_cyc = jc; end
            if (wv_load) begin
                if (wv_a < 0) wv_a = jc;
                else if (wv_b < 0) wv_b = jc;
            end
            if (block_sel != prev_bsel) begin ch_cyc.push_back(jc); ch_val.push_back(int'(block_sel)); end
            prev_bsel = block_sel;
            if (digest_capture) cap_cyc = jc;
            if (chunk_idx == 2'd2 && idx2_cyc < 0) idx2_cyc = jc;
            chunk_valid = e.cv;
            start       = e.st;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk("reset", int'({chunk_req, chunk_idx, block_sel, wv_load, round_en, round_idx,
                              digest_capture, busy, done}), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // plain job, source always ready
        gap(2); job(0, 1'b0); gap(3); play(100000);
        chk("a_done", done_cyc, T_DONE);
        chk("a_wv0", wv_a, 3);
        chk("a_wv1", wv_b, 70);
        chk("a_bsel_n", ch_cyc.size(), NCH == 3 ? 4 : 2);
        chk("a_bsel1_cyc", ch_cyc[0], 68); chk("a_bsel1_val", ch_val[0], 1);
        chk("a_bsel2_cyc", ch_cyc[1], 135); chk("a_bsel2_val", ch_val[1], 2);
`ifdef DOUBLE_HASH_EN
        chk("a_cap", cap_cyc, 136);
        chk("a_idx2", idx2_cyc, 137);
        chk("a_bsel0_cyc", ch_cyc[2], 137); chk("a_bsel0_val", ch_val[2], 0);
        chk("a_bsel1b_cyc", ch_cyc[3], 204); chk("a_bsel1b_val", ch_val[3], 1);
`else
        chk("a_cap", cap_cyc, -1);
        chk("a_idx2", idx2_cyc, -1);
`endif

        // source stalls 5 cycles in every WAIT
        job(5, 1'b0); gap(3); play(100000);
        chk("b_done", done_cyc, T_DONE + 5 * NCH);
        chk("b_wv0", wv_a, 8);

        // start pulsed during ROUND and DONE must be ignored
        job(0, 1'b1); gap(4); play(100000);
        chk("c_ndone", n_done, 1);
        chk("c_done", done_cyc, T_DONE);

        // reset during round 30 of chunk 1
        job(0, 1'b0); play(102);
        chk("d_ridx_pre", int'(round_idx), 30);
        #2 rst = 1'b1;
        #1 chk("d_busy", int'(busy), 0);
        chk("d_bsel", int'(block_sel), 0);
        chk("d_idx", int'(chunk_idx), 0);
        chk("d_ridx", int'(round_idx), 0);
        chk("d_ren", int'(round_en), 0);
        q.delete(); m_bsel = 2'd0; m_idx = 2'd0; prev_bsel = 2'd0;
        start = 1'b0; chunk_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // fresh job after the reset completes normally
        gap(2); job(0, 1'b0); gap(2); play(100000);
        chk("e_done", done_cyc, T_DONE);
        chk("e_ndone", n_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
